blink_sequencer: RTL and testbench
==================================

# blink_sequencer

Sequences a status LED through programmable blink patterns on the 50 MHz board clock. The pattern is N on/off blinks, an optional gap, then either a single run or an endless repeat. The block owns its own tick divider, so the pattern is cycle-exact and restarts aligned to each accepted start. It sits between board control logic (buttons, fault flags) and the LED pin, and replaces free-running divider blinkers wherever a counted pattern is needed.

## Interface
- CLK_HZ, 50000000: input clock frequency in Hz.
- TICK_HZ, 10: pattern tick rate. DIV = CLK_HZ/TICK_HZ clock cycles per tick; requires DIV ≥ 2.
- CNT_W, 4: width of the count and duration fields.

- clk_50MHz  in  1  board clock; every register uses its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a pattern; sampled only in IDLE.
- abort  in  1  stop the pattern immediately; no done pulse.
- blink_count  in  CNT_W  number of on/off blinks; 0 means start is ignored.
- on_ticks  in  CNT_W  ticks per ON phase; 0 is treated as 1.
- off_ticks  in  CNT_W  ticks per OFF phase; 0 is treated as 1.
- gap_ticks  in  CNT_W  ticks in the GAP phase; 0 skips GAP.
- repeat  in  1  loop the pattern until abort.
- led  out  1  LED drive, registered.
- busy  out  1  high from the edge after start is accepted until the return to IDLE.
- done  out  1  one-cycle pulse on normal completion.
- pause  in  1  present only with BLINK_SEQ_PAUSE_EN (see Configuration).

## Operation
- States: IDLE, ON, OFF, GAP.
- Reset: state = IDLE; led = 0, busy = 0, done = 0; all counters = 0.
- IDLE → ON when start=1, abort=0 and blink_count≠0.
  - blink_count, on_ticks, off_ticks, gap_ticks and repeat are latched at that edge.
  - The tick divider is cleared and the blink counter is set to 1.
- A phase ends at the tick on which phase_cnt == duration−1.
  - phase_cnt is cleared on every phase entry.
- ON → OFF at the end of the ON phase.
- OFF → ON when blink counter < latched count; the blink counter increments.
- OFF → GAP at the end of the final OFF phase when gap_ticks≠0.
- OFF → (end of pattern) at the end of the final OFF phase when gap_ticks=0.
- GAP → (end of pattern) at the end of the GAP phase.
- End of pattern:
  - repeat latched = 1: go to ON, blink counter = 1, done is not pulsed.
  - repeat latched = 0: go to IDLE and pulse done.
- led = 1 only in ON.
- abort in any non-IDLE state → IDLE at the next edge; led = 0, busy = 0, no done.
- Simultaneous events:
  - start and abort together in IDLE: abort wins and start is ignored.
  - start while busy: ignored.
  - Input changes while busy have no effect, because all settings were latched at start.
- rst mid-pattern: returns to the reset state at the next edge; no done.

## Timing
- Latency: start sampled at edge k gives led=1 and busy=1 visible after edge k.
- Phase lengths are exact:
  - ON lasts on_ticks·DIV cycles.
  - OFF lasts off_ticks·DIV cycles.
  - GAP lasts gap_ticks·DIV cycles.
- Tick divider counts 0..DIV−1 and wraps; tick = (div_cnt == DIV−1).
- Total busy time for a single run: blink_count·(on+off)·DIV + gap·DIV cycles.
- done is high for exactly 1 cycle, in the first cycle with busy=0.
- A new start is accepted in the done cycle itself.
- Counter widths: div_cnt is $clog2(DIV) bits; phase_cnt and the blink counter are CNT_W bits.
  - phase_cnt and the blink counter never wrap, because each phase ends at its limit.

## Configuration
- BLINK_SEQ_PAUSE_EN defined:
  - The pause port exists.
  - While pause=1 and busy: div_cnt and phase_cnt hold, and led holds its value.
  - abort and rst still take effect during pause.
- BLINK_SEQ_PAUSE_EN undefined:
  - No pause port.
  - Behaviour is identical to pause tied to 0.

## Structure
- Package blink_pkg holds:
  - the state enum (IDLE, ON, OFF, GAP);
  - the default CNT_W;
  - a function that computes the DIV width.
- Sub-module tick_gen (parameter DIV) holds the divider.
  - Inputs: clk_50MHz, rst, clr, hold.
  - Output: tick.
  - clr has priority over hold.
- The FSM, the phase/blink counters and the latched settings live in blink_sequencer.

## Test plan
Bench parameters: CLK_HZ=100, TICK_HZ=10, so DIV=10.
- Basic run: rst 2 cycles; start at edge 0 with count=2, on=1, off=1, gap=0, repeat=0.
  - led high for cycles 1–10 and 21–30, low for 11–20 and 31–40.
  - busy high for cycles 1–40; done=1 in cycle 41 only.
- Gap and repeat: count=1, on=2, off=1, gap=3, repeat=1.
  - Pattern period is 60 cycles (led high 20, low 40) and repeats.
  - done never pulses; abort at cycle 75 gives led=0, busy=0 from cycle 76 and no done.
- Zero fields: count=0 → start ignored, busy stays 0.
  - on=0, off=0, count=1 → led high for 10 cycles, then low for 10 cycles.
- Collisions:
  - start with abort in IDLE → no activity.
  - start while busy → pattern timing unchanged.
  - start in the done cycle → new run starts.
- Reset mid-run: rst at cycle 15 of the basic run → led, busy and done all 0 from cycle 16; a subsequent start runs normally.
- Pause (BLINK_SEQ_PAUSE_EN defined): pause high for 7 cycles during ON → ON phase lengthens by exactly 7 cycles and total busy time rises by 7.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared types and helpers for the blink sequencer: FSM state encoding,
// default field width and divider width calculation.
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int CNT_W_DEFAULT = 4;

    // Divider counter width; a 1-bit floor keeps degenerate dividers legal.
    function automatic int div_width(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/blink_sequencer_if.sv
// Control/status bundle between board logic and the blink sequencer.
// The pause signal exists only when BLINK_SEQ_PAUSE_EN is defined.
interface blink_sequencer_if #(
    parameter int CNT_W = blink_pkg::CNT_W_DEFAULT
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] blink_count;
    logic [CNT_W-1:0] on_ticks;
    logic [CNT_W-1:0] off_ticks;
    logic [CNT_W-1:0] gap_ticks;
    logic             repeat_en;   // "repeat" is a reserved word
    logic             led;
    logic             busy;
    logic             done;
`ifdef BLINK_SEQ_PAUSE_EN
    logic             pause;

    modport master (
        output start, abort, blink_count, on_ticks, off_ticks, gap_ticks, repeat_en, pause,
        input  led, busy, done
    );
    modport slave (
        input  start, abort, blink_count, on_ticks, off_ticks, gap_ticks, repeat_en, pause,
        output led, busy, done
    );
`else
    modport master (
        output start, abort, blink_count, on_ticks, off_ticks, gap_ticks, repeat_en,
        input  led, busy, done
    );
    modport slave (
        input  start, abort, blink_count, on_ticks, off_ticks, gap_ticks, repeat_en,
        output led, busy, done
    );
`endif
endinterface

// File: rtl/blink_sequencer_tick_gen.sv
// Tick divider: counts 0..DIV-1 and flags the last count. clr restarts the
// count (beats hold); hold freezes it and masks the tick.
module tick_gen
    import blink_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk_50MHz,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic tick
);
    localparam int              W    = div_width(DIV);
    localparam logic [W-1:0]    LAST = W'(DIV - 1);

    logic [W-1:0] r_div_cnt;

    always_ff @(posedge clk_50MHz) begin
        if (rst || clr) begin
            r_div_cnt <= '0;
        end else if (!hold) begin
            if (r_div_cnt == LAST) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    assign tick = (r_div_cnt == LAST) && !hold;

endmodule

// File: rtl/blink_sequencer.sv
// Counted LED blink pattern generator: N on/off blinks, optional gap, single
// or repeating. Optional pause input enabled by BLINK_SEQ_PAUSE_EN.
module blink_sequencer
    import blink_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 10,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic               clk_50MHz,
    input  logic               rst,
    blink_sequencer_if.slave   bus
);
    localparam int DIV = CLK_HZ / TICK_HZ;

    state_t           r_state;
    logic             r_led;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_phase_cnt;
    logic [CNT_W-1:0] r_blink_cnt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_on_last;
    logic [CNT_W-1:0] r_off_last;
    logic [CNT_W-1:0] r_gap_last;
    logic             r_gap_en;
    logic             r_repeat;

    logic             w_pause;
    logic             w_hold;
    logic             w_accept;
    logic             w_tick;
    logic [CNT_W-1:0] w_phase_last;
    logic             w_phase_end;

`ifdef BLINK_SEQ_PAUSE_EN
    assign w_pause = bus.pause;
`else
    assign w_pause = 1'b0;
`endif

    assign w_hold   = w_pause && (r_state != IDLE);
    assign w_accept = (r_state == IDLE) && bus.start && !bus.abort && (bus.blink_count != '0);

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .clr       (w_accept),
        .hold      (w_hold),
        .tick      (w_tick)
    );

    always_comb begin
        w_phase_last = '0;
        case (r_state)
            ON:      w_phase_last = r_on_last;
            OFF:     w_phase_last = r_off_last;
            GAP:     w_phase_last = r_gap_last;
            default: w_phase_last = '0;
        endcase
    end

    assign w_phase_end = w_tick && (r_phase_cnt == w_phase_last);

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            r_state     <= IDLE;
            r_led       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_phase_cnt <= '0;
            r_blink_cnt <= '0;
            r_count     <= '0;
            r_on_last   <= '0;
            r_off_last  <= '0;
            r_gap_last  <= '0;
            r_gap_en    <= 1'b0;
            r_repeat    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != IDLE && bus.abort) begin
                r_state     <= IDLE;
                r_led       <= 1'b0;
                r_busy      <= 1'b0;
                r_phase_cnt <= '0;
                r_blink_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            // Durations are stored as "last count", with 0 treated as 1.
                            r_count     <= bus.blink_count;
                            r_on_last   <= (bus.on_ticks  == '0) ? '0 : bus.on_ticks  - 1'b1;
                            r_off_last  <= (bus.off_ticks == '0) ? '0 : bus.off_ticks - 1'b1;
                            r_gap_last  <= bus.gap_ticks - 1'b1;
                            r_gap_en    <= (bus.gap_ticks != '0);
                            r_repeat    <= bus.repeat_en;
                            r_state     <= ON;
                            r_led       <= 1'b1;
                            r_busy      <= 1'b1;
                            r_phase_cnt <= '0;
                            r_blink_cnt <= CNT_W'(1);
                        end
                    end
                    ON: begin
                        if (w_phase_end) begin
                            r_state     <= OFF;
                            r_led       <= 1'b0;
                            r_phase_cnt <= '0;
                        end else if (w_tick) begin
                            r_phase_cnt <= r_phase_cnt + 1'b1;
                        end
                    end
                    OFF: begin
                        if (w_phase_end) begin
                            r_phase_cnt <= '0;
                            if (r_blink_cnt < r_count) begin
                                r_state     <= ON;
                                r_led       <= 1'b1;
                                r_blink_cnt <= r_blink_cnt + 1'b1;
                            end else if (r_gap_en) begin
                                r_state <= GAP;
                            end else if (r_repeat) begin
                                r_state     <= ON;
                                r_led       <= 1'b1;
                                r_blink_cnt <= CNT_W'(1);
                            end else begin
                                r_state     <= IDLE;
                                r_busy      <= 1'b0;
                                r_done      <= 1'b1;
                                r_blink_cnt <= '0;
                            end
                        end else if (w_tick) begin
                            r_phase_cnt <= r_phase_cnt + 1'b1;
                        end
                    end
                    GAP: begin
                        if (w_phase_end) begin
                            r_phase_cnt <= '0;
                            if (r_repeat) begin
                                r_state     <= ON;
                                r_led       <= 1'b1;
                                r_blink_cnt <= CNT_W'(1);
                            end else begin
                                r_state     <= IDLE;
                                r_busy      <= 1'b0;
                                r_done      <= 1'b1;
                                r_blink_cnt <= '0;
                            end
                        end else if (w_tick) begin
                            r_phase_cnt <= r_phase_cnt + 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.led  = r_led;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_blink_sequencer.sv
// Scoreboard bench for blink_sequencer at DIV=10: stimulus queues per-cycle
// expected led/busy/done, a negedge monitor pops and compares.
module tb_blink_sequencer;
    import blink_pkg::*;

    localparam int DIV = 10;

    typedef struct {
        string tag;
        int    idx;
        logic  led;
        logic  busy;
        logic  done;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    blink_sequencer_if #(.CNT_W(4)) bus ();

    blink_sequencer #(.CLK_HZ(100), .TICK_HZ(10), .CNT_W(4)) dut (
        .clk_50MHz (clk),
        .rst       (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (bus.led !== e.led || bus.busy !== e.busy || bus.done !== e.done) begin
                failures++;
                $display("FAIL %s cycle=%0d got led/busy/done=%b%b%b want %b%b%b",
                         e.tag, e.idx, bus.led, bus.busy, bus.done, e.led, e.busy, e.done);
            end else begin
                $display("ok   %s cycle=%0d led/busy/done=%b%b%b",
                         e.tag, e.idx, bus.led, bus.busy, bus.done);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic set_cfg(input int cnt, input int on, input int off, input int gap, input bit rpt);
        bus.blink_count = 4'(cnt);
        bus.on_ticks    = 4'(on);
        bus.off_ticks   = 4'(off);
        bus.gap_ticks   = 4'(gap);
        bus.repeat_en   = rpt;
    endtask

    function automatic void push_const(input string tag, input int n, input logic l, input logic b, input logic d);
        for (int i = 1; i <= n; i++) begin
            exp_t e;
            e.tag = tag; e.idx = i; e.led = l; e.busy = b; e.done = d;
            exp_q.push_back(e);
        end
    endfunction

    // Closed-form pattern: cycle c (1 = first cycle after the start edge).
    function automatic void push_run(input string tag, input int cnt, input int on, input int off,
                                     input int gap, input bit rpt, input int ncyc);
        int onp, offp, per, len, p;
        onp  = (on  == 0) ? 1 : on;
        offp = (off == 0) ? 1 : off;
        per  = (onp + offp) * DIV;
        len  = cnt * per + gap * DIV;
        for (int c = 1; c <= ncyc; c++) begin
            exp_t e;
            e.tag = tag; e.idx = c;
            if (rpt || c <= len) begin
                p      = (c - 1) % len;
                e.led  = (p < cnt * per) && ((p % per) < onp * DIV);
                e.busy = 1'b1;
                e.done = 1'b0;
            end else begin
                e.led  = 1'b0;
                e.busy = 1'b0;
                e.done = (c == len + 1);
            end
            exp_q.push_back(e);
        end
    endfunction

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
`ifdef BLINK_SEQ_PAUSE_EN
        bus.pause = 1'b0;
`endif
        set_cfg(0, 0, 0, 0, 1'b0);
        rst = 1'b1;
        wait_n(2);
        rst = 1'b0;
        push_const("reset", 3, 1'b0, 1'b0, 1'b0);
        wait_n(3);

        // Basic single run
        set_cfg(2, 1, 1, 0, 1'b0);
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        push_run("basic", 2, 1, 1, 0, 1'b0, 45);
        wait_n(45);

        // Gap + repeat, start and setting changes while busy, abort at cycle 75
        set_cfg(1, 2, 1, 3, 1'b1);
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        push_run("gap_repeat", 1, 2, 1, 3, 1'b1, 75);
        push_const("after_abort", 5, 1'b0, 1'b0, 1'b0);
        wait_n(29);
        set_cfg(5, 1, 4, 0, 1'b0);
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        wait_n(44);
        bus.abort = 1'b1; cyc(); bus.abort = 1'b0;
        wait_n(5);

        // Zero blink count: ignored
        set_cfg(0, 1, 1, 0, 1'b0);
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        push_const("zero_count", 5, 1'b0, 1'b0, 1'b0);
        wait_n(5);

        // Zero durations act as 1, then restart in the done cycle
        set_cfg(1, 0, 0, 0, 1'b0);
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        push_run("zero_dur", 1, 0, 0, 0, 1'b0, 21);
        wait_n(20);
        set_cfg(1, 1, 2, 0, 1'b0);
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        push_run("done_cycle_start", 1, 1, 2, 0, 1'b0, 32);
        wait_n(32);

        // start with abort in IDLE
        set_cfg(2, 1, 1, 0, 1'b0);
        bus.start = 1'b1; bus.abort = 1'b1; cyc(); bus.start = 1'b0; bus.abort = 1'b0;
        push_const("start_abort", 5, 1'b0, 1'b0, 1'b0);
        wait_n(5);

        // Reset mid-run, then a normal run
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        push_run("rst_mid", 2, 1, 1, 0, 1'b0, 15);
        push_const("rst_after", 5, 1'b0, 1'b0, 1'b0);
        wait_n(14);
        rst = 1'b1; cyc(); rst = 1'b0;
        wait_n(5);
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        push_run("post_rst", 2, 1, 1, 0, 1'b0, 45);
        wait_n(45);

`ifdef BLINK_SEQ_PAUSE_EN
        // Pause 7 cycles inside ON: ON 27 cycles, OFF 10, done in cycle 38
        set_cfg(1, 2, 1, 0, 1'b0);
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        push_const("pause_on", 27, 1'b1, 1'b1, 1'b0);
        push_const("pause_off", 10, 1'b0, 1'b1, 1'b0);
        push_const("pause_done", 1, 1'b0, 1'b0, 1'b1);
        push_const("pause_idle", 2, 1'b0, 1'b0, 1'b0);
        wait_n(4);
        bus.pause = 1'b1; wait_n(7); bus.pause = 1'b0;
        wait_n(29);
`endif

        wait_n(2);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got %0d entries want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
